// File: rtl/id_ex_skid_buffer.sv
// id_ex_skid_buffer: two-entry ID->EX skid buffer with registered in_ready, flush and stall counter.
// Revision 1.0
`default_nettype none

package rv32i_pkg;
    typedef struct packed {
        logic [3:0] ex;
        logic [1:0] mem;
        logic [1:0] wb;
        logic       load_regfile;
    } rv32i_ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        rv32i_ctrl_t ctrl;
    } rv32i_packet_t;
endpackage

module id_ex_skid_buffer #(
    parameter int CNT_W = 32,
    parameter int PKT_W = $bits(rv32i_pkg::rv32i_packet_t)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PKT_W-1:0] in_pkt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PKT_W-1:0] out_pkt,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             main_v;
    logic             skid_v;
    logic [PKT_W-1:0] main_pkt;
    logic [PKT_W-1:0] skid_pkt;
    logic             accept;
    logic             pop;

    assign accept    = in_valid & in_ready;
    assign pop       = main_v & out_ready;
    assign out_valid = main_v;
    // Zeroed packet doubles as a NOP control word for EX.
    assign out_pkt   = main_v ? main_pkt : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_v   <= 1'b0;
            skid_v   <= 1'b0;
            main_pkt <= '0;
            skid_pkt <= '0;
            in_ready <= 1'b1;
        end else if (flush) begin
            main_v   <= 1'b0;
            skid_v   <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            case ({main_v, skid_v})
                2'b00: begin
                    if (accept) begin
                        main_pkt <= in_pkt;
                        main_v   <= 1'b1;
                    end
                end
                2'b10: begin
                    if (pop && accept) begin
                        main_pkt <= in_pkt;
                    end else if (pop) begin
                        main_v <= 1'b0;
                    end else if (accept) begin
                        skid_pkt <= in_pkt;
                        skid_v   <= 1'b1;
                        in_ready <= 1'b0;
                    end
                end
                2'b11: begin
                    if (pop) begin
                        main_pkt <= skid_pkt;
                        skid_v   <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    // skid without main cannot occur; recover to EMPTY
                    main_v   <= 1'b0;
                    skid_v   <= 1'b0;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (main_v && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire
